// File: rtl/microwave_cook_ctrl.sv
// Microwave oven cook sequencer: keypad entry of M:SS in BCD, 1 s countdown,
// magnetron enable and display blank.
module microwave_cook_ctrl #(
  parameter int TICK_DIV = 100,
  parameter int TICK_W   = 7
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [9:0]  key,
  input  logic        startn,
  input  logic        stopn,
  input  logic        door_closed,
  output logic [3:0]  min_bcd,
  output logic [3:0]  sec_tens_bcd,
  output logic [3:0]  sec_ones_bcd,
  output logic        mag_on,
  output logic        blank,
  output logic        done
);

  // state | meaning
  // IDLE  | no time entered, display blanked, digits 0:00
  // ENTRY | keypad digits being shifted in
  // COOK  | counting down, magnetron on while door closed
  // PAUSE | countdown held by stop or open door
  typedef enum logic [1:0] {IDLE, ENTRY, COOK, PAUSE} state_t;

  state_t            state;
  logic [3:0]        min_d, tens_d, ones_d;
  logic [TICK_W-1:0] presc;
  logic              start_hist, stop_hist, key_hist_idle;

  logic              start_ev, stop_ev, key_ev, key_ok;
  logic [3:0]        key_cnt, key_val;
  logic              time_zero, last_sec, tick;
  logic [3:0]        min_dec, tens_dec, ones_dec;

  assign start_ev = ~startn & start_hist;
  assign stop_ev  = ~stopn & stop_hist;
  assign key_ev   = (key != '0) & key_hist_idle;

  always_comb begin
    key_cnt = '0;
    key_val = '0;
    for (int i = 0; i < 10; i++) begin
      if (key[i]) begin
        key_cnt = key_cnt + 4'd1;
        key_val = 4'(i);
      end
    end
  end

  // Current ones digit moves into the tens position, which cannot exceed 5.
  assign key_ok    = key_ev && (key_cnt == 4'd1) && (ones_d <= 4'd5);
  assign time_zero = (min_d == 4'd0) && (tens_d == 4'd0) && (ones_d == 4'd0);
  assign last_sec  = (min_d == 4'd0) && (tens_d == 4'd0) && (ones_d == 4'd1);
  assign tick      = (presc == TICK_W'(TICK_DIV - 1));

  always_comb begin
    min_dec  = min_d;
    tens_dec = tens_d;
    ones_dec = ones_d - 4'd1;
    if (ones_d == 4'd0) begin
      ones_dec = 4'd9;
      tens_dec = tens_d - 4'd1;
      if (tens_d == 4'd0) begin
        tens_dec = 4'd5;
        min_dec  = min_d - 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state         <= IDLE;
      min_d         <= '0;
      tens_d        <= '0;
      ones_d        <= '0;
      presc         <= '0;
      done          <= 1'b0;
      start_hist    <= 1'b0;
      stop_hist     <= 1'b0;
      key_hist_idle <= 1'b0;
    end else begin
      start_hist    <= startn;
      stop_hist     <= stopn;
      key_hist_idle <= (key == '0);
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (key_ok) begin
            min_d  <= tens_d;
            tens_d <= ones_d;
            ones_d <= key_val;
            state  <= ENTRY;
          end
        end
        ENTRY: begin
          if (stop_ev) begin
            min_d  <= '0;
            tens_d <= '0;
            ones_d <= '0;
            state  <= IDLE;
          end else if (start_ev && door_closed && !time_zero) begin
            presc <= '0;
            state <= COOK;
          end else if (key_ok) begin
            min_d  <= tens_d;
            tens_d <= ones_d;
            ones_d <= key_val;
          end
        end
        COOK: begin
          if (stop_ev || !door_closed) begin
            state <= PAUSE;
          end else if (tick) begin
            presc <= '0;
            if (last_sec) begin
              min_d  <= '0;
              tens_d <= '0;
              ones_d <= '0;
              done   <= 1'b1;
              state  <= IDLE;
            end else begin
              min_d  <= min_dec;
              tens_d <= tens_dec;
              ones_d <= ones_dec;
            end
          end else begin
            presc <= presc + TICK_W'(1);
          end
        end
        PAUSE: begin
          // Prescaler is deliberately held so a resumed cook keeps its partial second.
          if (stop_ev) begin
            min_d  <= '0;
            tens_d <= '0;
            ones_d <= '0;
            state  <= IDLE;
          end else if (start_ev && door_closed) begin
            state <= COOK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign min_bcd      = min_d;
  assign sec_tens_bcd = tens_d;
  assign sec_ones_bcd = ones_d;
  assign mag_on       = (state == COOK) && door_closed;
  assign blank        = (state == IDLE);

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Directed bench for microwave_cook_ctrl; expected values are hand-computed.
module tb_microwave_cook_ctrl;

  logic        clock = 1'b0;
  logic        clear;
  logic [9:0]  key;
  logic        startn, stopn, door_closed;
  logic [3:0]  min_bcd, sec_tens_bcd, sec_ones_bcd;
  logic        mag_on, blank, done;
  logic [11:0] digits;

  int checks_total  = 0;
  int checks_passed = 0;

  microwave_cook_ctrl #(.TICK_DIV(100), .TICK_W(7)) dut (
    .clock        (clock),
    .clear        (clear),
    .key          (key),
    .startn       (startn),
    .stopn        (stopn),
    .door_closed  (door_closed),
    .min_bcd      (min_bcd),
    .sec_tens_bcd (sec_tens_bcd),
    .sec_ones_bcd (sec_ones_bcd),
    .mag_on       (mag_on),
    .blank        (blank),
    .done         (done)
  );

  assign digits = {min_bcd, sec_tens_bcd, sec_ones_bcd};

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press_key(input int d);
    key = 10'(1 << d);
    cyc(1);
    key = '0;
    cyc(1);
  endtask

  task automatic press_start();
    startn = 1'b0;
    cyc(1);
    startn = 1'b1;
    cyc(1);
  endtask

  task automatic press_stop();
    stopn = 1'b0;
    cyc(1);
    stopn = 1'b1;
    cyc(1);
  endtask

  initial begin
    clear = 1'b1; key = '0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
    cyc(3);
    clear = 1'b0;
    cyc(1);
    check("rst_digits", 32'(digits), 32'h000);
    check("rst_blank",  32'(blank),  32'd1);
    check("rst_mag",    32'(mag_on), 32'd0);
    check("rst_done",   32'(done),   32'd0);

    // entry and shifting
    press_key(4);
    press_key(1);
    check("t1_041",   32'(digits), 32'h041);
    check("t1_blank", 32'(blank),  32'd0);
    press_key(2);
    check("t1_412", 32'(digits), 32'h412);
    press_key(3);
    check("t1_123_min_dropped", 32'(digits), 32'h123);
    press_stop();
    check("t1_stop_digits", 32'(digits), 32'h000);
    check("t1_stop_blank",  32'(blank),  32'd1);

    // 0:02 countdown to done
    press_key(2);
    press_start();
    check("t2_mag_on", 32'(mag_on), 32'd1);
    check("t2_blank",  32'(blank),  32'd0);
    cyc(98);
    check("t2_pre_tick", 32'(digits), 32'h002);
    cyc(1);
    check("t2_tick1", 32'(digits), 32'h001);
    cyc(99);
    check("t2_pre_tick2", 32'(digits), 32'h001);
    check("t2_no_done",   32'(done),   32'd0);
    cyc(1);
    check("t2_end_digits", 32'(digits), 32'h000);
    check("t2_done",       32'(done),   32'd1);
    check("t2_end_mag",    32'(mag_on), 32'd0);
    check("t2_end_blank",  32'(blank),  32'd1);
    cyc(1);
    check("t2_done_once", 32'(done), 32'd0);

    // start with door open is ignored
    door_closed = 1'b0;
    press_key(1);
    press_start();
    check("t3_open_mag",   32'(mag_on), 32'd0);
    check("t3_open_blank", 32'(blank),  32'd0);
    press_key(2);
    check("t3_still_entry", 32'(digits), 32'h012);
    door_closed = 1'b1;
    press_start();
    check("t3_cook", 32'(mag_on), 32'd1);
    press_stop();
    check("t3_pause_mag",    32'(mag_on), 32'd0);
    check("t3_pause_digits", 32'(digits), 32'h012);
    press_stop();
    check("t3_idle_digits", 32'(digits), 32'h000);
    check("t3_idle_blank",  32'(blank),  32'd1);

    // door open mid-second, resume keeps prescaler
    press_key(1);
    press_key(0);
    press_key(0);
    check("t4_100", 32'(digits), 32'h100);
    press_start();
    cyc(48);
    door_closed = 1'b0;
    #1;
    check("t4_mag_falls", 32'(mag_on), 32'd0);
    cyc(1);
    check("t4_pause_digits", 32'(digits), 32'h100);
    check("t4_pause_blank",  32'(blank),  32'd0);
    door_closed = 1'b1;
    cyc(1);
    check("t4_pause_door_closed_mag", 32'(mag_on), 32'd0);
    press_start();
    check("t4_resume_mag", 32'(mag_on), 32'd1);
    cyc(49);
    check("t4_pre_tick", 32'(digits), 32'h100);
    cyc(1);
    check("t4_tick_059", 32'(digits), 32'h059);

    // start and stop together: stop wins
    startn = 1'b0; stopn = 1'b0;
    cyc(1);
    startn = 1'b1; stopn = 1'b1;
    check("t5_both_mag",   32'(mag_on), 32'd0);
    check("t5_both_blank", 32'(blank),  32'd0);
    cyc(1);
    check("t5_hold_digits", 32'(digits), 32'h059);
    press_stop();
    check("t5_idle_digits", 32'(digits), 32'h000);
    check("t5_idle_blank",  32'(blank),  32'd1);

    // rejected and invalid keys
    press_key(7);
    check("t6_007", 32'(digits), 32'h007);
    press_key(8);
    check("t6_reject_tens", 32'(digits), 32'h007);
    key = 10'b0000000110;
    cyc(1);
    key = '0;
    cyc(1);
    check("t6_two_keys", 32'(digits), 32'h007);
    press_stop();
    press_key(5);
    press_key(9);
    check("t6_059_edge", 32'(digits), 32'h059);
    press_key(9);
    check("t6_reject_9", 32'(digits), 32'h059);
    press_stop();

    // buttons held through clear do not fire
    startn = 1'b0;
    key = 10'(1 << 5);
    clear = 1'b1;
    cyc(2);
    clear = 1'b0;
    cyc(3);
    check("t6_held_key_digits", 32'(digits), 32'h000);
    check("t6_held_key_blank",  32'(blank),  32'd1);
    key = '0;
    cyc(1);
    press_key(3);
    cyc(2);
    check("t6_held_start_digits", 32'(digits), 32'h003);
    check("t6_held_start_mag",    32'(mag_on), 32'd0);
    startn = 1'b1;
    cyc(1);
    press_start();
    check("t6_fresh_start", 32'(mag_on), 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
